// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory arbiter.
package mem_arb_pkg;

    // Whose response is due in the current cycle
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_RESP = 2'd1,
        DM_RESP = 2'd2
    } type_mem_arb_state_e;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_IF   = 2'd1,
        GNT_DM   = 2'd2
    } type_mem_arb_gnt_e;

    localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Starvation counter: counts data grants issued while fetch waits and flags a forced fetch grant.
module mem_arb_starve_cnt
    import mem_arb_pkg::*;
#(
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ifr,
    input  type_mem_arb_gnt_e gnt,
    output logic              force_if
);

    localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!ifr || gnt == GNT_IF) begin
            cnt <= '0;
        end else if (gnt == GNT_DM && cnt != 4'hF) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign force_if = ifr && (cnt == CNT_MAX);

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter in front of a single-port SRAM with 1-cycle read latency.
// Optional starvation guard enabled by defining MEM_ARB_STARVE_GUARD_EN.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    output logic                if_ack_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                dmem_sel_i,
    input  logic                dbus_req_i,
    input  logic [ADDR_W-1:0]   dbus_addr_i,
    input  logic [DATA_W-1:0]   dbus_wdata_i,
    input  logic                dbus_we_i,
    input  logic [DATA_W/8-1:0] dbus_be_i,
    output logic                dbus_ack_o,
    output logic [DATA_W-1:0]   dbus_rdata_o,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve_max
        $error("mem_arbiter: STARVE_MAX must be in 1..15");
    end

    type_mem_arb_state_e state, state_nxt;
    type_mem_arb_gnt_e   gnt;
    logic                ifr, dmr, if_ok, dm_ok, force_if, dm_we;

    assign ifr   = if_req_i;
    assign dmr   = dbus_req_i & dmem_sel_i;
    // A requester is still holding req in its own ack cycle; keep it out of the grant.
    assign if_ok = ifr & (state != IF_RESP);
    assign dm_ok = dmr & (state != DM_RESP);

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic force_raw;

    mem_arb_starve_cnt #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .ifr      (ifr),
        .gnt      (gnt),
        .force_if (force_raw)
    );

    assign force_if = force_raw & if_ok;
`else
    assign force_if = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Remembers whether the pending data response is a write (no read data returned)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_we <= 1'b0;
        end else if (gnt == GNT_DM) begin
            dm_we <= dbus_we_i;
        end
    end

    always_comb begin
        gnt       = GNT_NONE;
        state_nxt = IDLE;
        if (!rst_n) begin
            gnt = GNT_NONE;
        end else if (force_if) begin
            gnt = GNT_IF;
        end else if (dm_ok) begin
            gnt = GNT_DM;
        end else if (if_ok) begin
            gnt = GNT_IF;
        end
        case (gnt)
            GNT_IF:  state_nxt = IF_RESP;
            GNT_DM:  state_nxt = DM_RESP;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        if_ack_o     = 1'b0;
        if_rdata_o   = '0;
        dbus_ack_o   = 1'b0;
        dbus_rdata_o = '0;
        mem_req_o    = 1'b0;
        mem_addr_o   = '0;
        mem_we_o     = 1'b0;
        mem_be_o     = '0;
        mem_wdata_o  = '0;
        case (state)
            IF_RESP: begin
                if_ack_o   = 1'b1;
                if_rdata_o = mem_rdata_i;
            end
            DM_RESP: begin
                dbus_ack_o = 1'b1;
                if (!dm_we) begin
                    dbus_rdata_o = mem_rdata_i;
                end
            end
            default: ;
        endcase
        case (gnt)
            GNT_IF: begin
                mem_req_o  = 1'b1;
                mem_addr_o = if_addr_i;
                mem_be_o   = '1;
            end
            GNT_DM: begin
                mem_req_o   = 1'b1;
                mem_addr_o  = dbus_addr_i;
                mem_we_o    = dbus_we_i;
                mem_be_o    = dbus_we_i ? dbus_be_i : '1;
                mem_wdata_o = dbus_wdata_i;
            end
            default: ;
        endcase
    end

endmodule
